// File: rtl/axi_arb_pkg.sv
// Shared types and constants for the per-slave AXI read-address arbiter.
// Payload packing is {ID, ADDR, LEN, SIZE, BURST}, with BURST in the LSBs.
package axi_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_ADDR = 2'd1,
    ARB_DATA = 2'd2
  } arb_state_e;

  localparam int AR_BURST_LSB = 0;
  localparam int AR_BURST_W   = 2;
  localparam int AR_SIZE_LSB  = 2;
  localparam int AR_SIZE_W    = 3;
  localparam int AR_LEN_LSB   = 5;
  localparam int AR_LEN_W     = 8;
  localparam int AR_ADDR_LSB  = 13;
  localparam int AR_ADDR_W    = 32;
  localparam int AR_ID_LSB    = 45;
  localparam int AR_ID_W      = 4;

  localparam int AXI_ARB_TO_CYC_DEF = 255;

endpackage

// File: rtl/axi_rr_pick.sv
// Purpose: combinational round-robin picker; the search starts at ptr and wraps modulo NUM_M.
// Latency: zero cycles (purely combinational).
// Backpressure: none; the caller decides when a grant is consumed.
module axi_rr_pick #(
  parameter int NUM_M = 2,
  parameter int MID_W = (NUM_M > 1) ? $clog2(NUM_M) : 1
) (
  input  logic [NUM_M-1:0] req,
  input  logic [MID_W-1:0] ptr,
  output logic [NUM_M-1:0] gnt_onehot,
  output logic [MID_W-1:0] gnt_idx,
  output logic             any
);

  always_comb begin
    int j;
    j          = 0;
    gnt_onehot = '0;
    gnt_idx    = '0;
    any        = 1'b0;
    for (int i = 0; i < NUM_M; i++) begin
      j = int'(ptr) + i;
      if (j >= NUM_M) j = j - NUM_M;
      if (!any && req[j]) begin
        any           = 1'b1;
        gnt_onehot[j] = 1'b1;
        gnt_idx       = MID_W'(j);
      end
    end
  end

endmodule

// File: rtl/axi_rd_slave_arbiter.sv
// Purpose: per-slave AR arbiter; holds one read per slave until the last R beat. Optional watchdog: AXI_ARB_TIMEOUT_EN.
// Latency: request to AR_VALID_o is 1 cycle; R-last handshake to the next req_ready_o is 1 cycle.
// Backpressure: AR_VALID_o is held until AR_READY_i; new requests wait in IDLE until the burst completes.
module axi_rd_slave_arbiter
  import axi_arb_pkg::*;
#(
  parameter int NUM_M  = 2,
  parameter int DATA_W = 49,
  parameter int TO_CYC = AXI_ARB_TO_CYC_DEF,
  localparam int MID_W = (NUM_M > 1) ? $clog2(NUM_M) : 1
) (
  input  logic                    AXI_CLK_i,
  input  logic                    AXI_RST_i,
  input  logic [NUM_M-1:0]        req_valid_i,
  input  logic [NUM_M*DATA_W-1:0] req_data_i,
  output logic [NUM_M-1:0]        req_ready_o,
  output logic                    AR_VALID_o,
  output logic [DATA_W-1:0]       AR_DATA_o,
  output logic [MID_W-1:0]        AR_MID_o,
  input  logic                    AR_READY_i,
  input  logic                    RVALID_i,
  input  logic                    RREADY_i,
  input  logic                    RLAST_i,
  output logic                    busy_o,
  output logic                    timeout_o
);

  arb_state_e        state_q, state_d;
  logic [MID_W-1:0]  rr_ptr_q;
  logic [DATA_W-1:0] ar_data_q;
  logic [MID_W-1:0]  ar_mid_q;

  logic [NUM_M-1:0]  gnt_onehot;
  logic [MID_W-1:0]  gnt_idx;
  logic              gnt_any;
  logic              gnt_take;
  logic              r_beat;
  logic              wd_hit;

  axi_rr_pick #(.NUM_M(NUM_M), .MID_W(MID_W)) u_pick (
    .req        (req_valid_i),
    .ptr        (rr_ptr_q),
    .gnt_onehot (gnt_onehot),
    .gnt_idx    (gnt_idx),
    .any        (gnt_any)
  );

  assign r_beat = RVALID_i & RREADY_i;

`ifdef AXI_ARB_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TO_CYC + 1) > 8) ? $clog2(TO_CYC + 1) : 8;
  logic [CNT_W-1:0] wd_cnt_q;

  // Counter holds completed DATA cycles since entry or the last beat.
  always_ff @(posedge AXI_CLK_i) begin
    if (AXI_RST_i) begin
      wd_cnt_q <= '0;
    end else if ((state_q == ARB_ADDR && AR_READY_i) || (state_q == ARB_DATA && r_beat)) begin
      wd_cnt_q <= '0;
    end else if (state_q == ARB_DATA) begin
      wd_cnt_q <= wd_cnt_q + CNT_W'(1);
    end
  end

  assign wd_hit = (state_q == ARB_DATA) && !r_beat && (wd_cnt_q == CNT_W'(TO_CYC - 1));
`else
  assign wd_hit = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    gnt_take = 1'b0;
    unique case (state_q)
      ARB_IDLE: begin
        if (gnt_any && !AXI_RST_i) begin
          gnt_take = 1'b1;
          state_d  = ARB_ADDR;
        end
      end
      ARB_ADDR: begin
        if (AR_READY_i) state_d = ARB_DATA;
      end
      ARB_DATA: begin
        if ((r_beat && RLAST_i) || wd_hit) state_d = ARB_IDLE;
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge AXI_CLK_i) begin
    if (AXI_RST_i) begin
      state_q   <= ARB_IDLE;
      rr_ptr_q  <= '0;
      ar_data_q <= '0;
      ar_mid_q  <= '0;
    end else begin
      state_q <= state_d;
      if (gnt_take) begin
        ar_data_q <= req_data_i[gnt_idx*DATA_W +: DATA_W];
        ar_mid_q  <= gnt_idx;
        // The granted master drops to lowest priority for the next round.
        rr_ptr_q  <= (gnt_idx == MID_W'(NUM_M - 1)) ? '0 : gnt_idx + MID_W'(1);
      end
    end
  end

  assign req_ready_o = gnt_take ? gnt_onehot : '0;
  assign AR_VALID_o  = (state_q == ARB_ADDR);
  assign AR_DATA_o   = ar_data_q;
  assign AR_MID_o    = ar_mid_q;
  assign busy_o      = (state_q != ARB_IDLE);
  assign timeout_o   = wd_hit;

endmodule

// File: tb/tb_axi_rd_slave_arbiter.sv
// Directed bench for axi_rd_slave_arbiter with NUM_M=2, DATA_W=49, TO_CYC=8.
module tb_axi_rd_slave_arbiter;

  localparam int NUM_M  = 2;
  localparam int DATA_W = 49;

  logic                    clk = 1'b0;
  logic                    rst;
  logic [NUM_M-1:0]        req_valid;
  logic [NUM_M*DATA_W-1:0] req_data;
  logic [NUM_M-1:0]        req_ready;
  logic                    ar_valid;
  logic [DATA_W-1:0]       ar_data;
  logic                    ar_mid;
  logic                    ar_ready;
  logic                    rvalid, rready, rlast;
  logic                    busy, timeout;

  int checks = 0;
  int errors = 0;

  localparam logic [DATA_W-1:0] M0 = 49'h0_1000_0000_01A5;
  localparam logic [DATA_W-1:0] M1 = 49'h1_2345_6789_ABCD;

  axi_rd_slave_arbiter #(.NUM_M(NUM_M), .DATA_W(DATA_W), .TO_CYC(8)) dut (
    .AXI_CLK_i   (clk),
    .AXI_RST_i   (rst),
    .req_valid_i (req_valid),
    .req_data_i  (req_data),
    .req_ready_o (req_ready),
    .AR_VALID_o  (ar_valid),
    .AR_DATA_o   (ar_data),
    .AR_MID_o    (ar_mid),
    .AR_READY_i  (ar_ready),
    .RVALID_i    (rvalid),
    .RREADY_i    (rready),
    .RLAST_i     (rlast),
    .busy_o      (busy),
    .timeout_o   (timeout)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic r_drive(input logic v, input logic r, input logic l);
    rvalid = v; rready = r; rlast = l;
  endtask

  task automatic do_reset();
    rst = 1'b1; req_valid = '0; ar_ready = 1'b0; r_drive(0, 0, 0);
    step(); step();
    rst = 1'b0;
  endtask

  // Grant master m from IDLE and complete the AR handshake, landing in DATA.
  task automatic to_data(input logic [NUM_M-1:0] vld);
    req_valid = vld; step();
    req_valid = '0; ar_ready = 1'b1; step();
    ar_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = '0; ar_ready = 1'b0; r_drive(0, 0, 0);
    req_data = {M1, M0};
    step(); step(); #1;
    checks++;
    if ({busy, ar_valid, req_ready, timeout} !== 5'b0 || ar_data !== '0 || ar_mid !== 1'b0) begin
      errors++;
      $display("FAIL reset_state got busy=%b arv=%b rdy=%b to=%b data=%h mid=%b required all zero",
               busy, ar_valid, req_ready, timeout, ar_data, ar_mid);
    end
  endtask

  task automatic test_first_grant();
    rst = 1'b0; req_valid = 2'b11; #1;
    checks++;
    if (req_ready !== 2'b01) begin
      errors++; $display("FAIL first_grant_ready got %b required 01", req_ready);
    end
    step(); req_valid = 2'b00; #1;
    checks++;
    if (ar_valid !== 1'b1 || ar_data !== M0 || ar_mid !== 1'b0 || req_ready !== 2'b00) begin
      errors++;
      $display("FAIL first_ar got v=%b data=%h mid=%b rdy=%b required 1 %h 0 00", ar_valid, ar_data, ar_mid, req_ready, M0);
    end
    ar_ready = 1'b1; step(); ar_ready = 1'b0; #1;
    checks++;
    if (ar_valid !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL first_data got arv=%b busy=%b required 0 1", ar_valid, busy);
    end
    r_drive(1, 1, 1); step(); r_drive(0, 0, 0); #1;
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL first_done got busy=%b required 0", busy);
    end
  endtask

  task automatic test_alternate();
    logic [1:0] exp_rdy;
    do_reset();
    req_valid = 2'b11; ar_ready = 1'b1; r_drive(1, 1, 1);
    for (int k = 0; k < 4; k++) begin
      exp_rdy = (k % 2 == 0) ? 2'b01 : 2'b10;
      #1;
      checks++;
      if (req_ready !== exp_rdy) begin
        errors++; $display("FAIL alt_ready[%0d] got %b required %b", k, req_ready, exp_rdy);
      end
      step();
      checks++;
      if (ar_valid !== 1'b1 || ar_mid !== exp_rdy[1] || ar_data !== (exp_rdy[1] ? M1 : M0)) begin
        errors++; $display("FAIL alt_ar[%0d] got v=%b mid=%b data=%h", k, ar_valid, ar_mid, ar_data);
      end
      step();
      checks++;
      if (req_ready !== 2'b00 || busy !== 1'b1) begin
        errors++; $display("FAIL alt_data[%0d] got rdy=%b busy=%b required 00 1", k, req_ready, busy);
      end
      step();
    end
    req_valid = '0; ar_ready = 1'b0; r_drive(0, 0, 0);
  endtask

  task automatic test_ar_stall();
    do_reset();
    req_valid = 2'b01; step();
    req_valid = 2'b10;
    for (int k = 0; k < 5; k++) begin
      #1;
      checks++;
      if (ar_valid !== 1'b1 || ar_data !== M0 || ar_mid !== 1'b0 || req_ready !== 2'b00) begin
        errors++;
        $display("FAIL stall[%0d] got v=%b data=%h mid=%b rdy=%b required 1 %h 0 00", k, ar_valid, ar_data, ar_mid, req_ready, M0);
      end
      // An R handshake outside DATA must be ignored.
      r_drive(k == 2, k == 2, k == 2);
      step();
      r_drive(0, 0, 0);
    end
    ar_ready = 1'b1; step(); ar_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      #1;
      checks++;
      if (req_ready !== 2'b00 || busy !== 1'b1 || ar_valid !== 1'b0) begin
        errors++; $display("FAIL stall_data[%0d] got rdy=%b busy=%b arv=%b required 00 1 0", k, req_ready, busy, ar_valid);
      end
      step();
    end
    r_drive(1, 1, 1); step(); r_drive(0, 0, 0); #1;
    checks++;
    if (req_ready !== 2'b10 || ar_mid !== 1'b0) begin
      errors++; $display("FAIL stall_regrant got rdy=%b mid=%b required 10 0", req_ready, ar_mid);
    end
  endtask

  task automatic test_burst();
    logic [3:0] tbl [8];
    tbl = '{4'b1001, 4'b1101, 4'b1001, 4'b1101, 4'b0111, 4'b1101, 4'b1011, 4'b1110};
    step(); req_valid = '0;
    checks++;
    if (ar_mid !== 1'b1 || ar_data !== M1) begin
      errors++; $display("FAIL burst_ar got mid=%b data=%h required 1 %h", ar_mid, ar_data, M1);
    end
    ar_ready = 1'b1; step(); ar_ready = 1'b0;
    for (int k = 0; k < 8; k++) begin
      r_drive(tbl[k][3], tbl[k][2], tbl[k][1]);
      step();
      checks++;
      if (busy !== tbl[k][0]) begin
        errors++; $display("FAIL burst_beat[%0d] got busy=%b required %b", k, busy, tbl[k][0]);
      end
    end
    r_drive(0, 0, 0);
    checks++;
    if (ar_mid !== 1'b1) begin
      errors++; $display("FAIL burst_mid_hold got %b required 1", ar_mid);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    to_data(2'b01);
    rst = 1'b1; step(); #1;
    checks++;
    if (busy !== 1'b0 || ar_valid !== 1'b0 || ar_mid !== 1'b0 || ar_data !== '0) begin
      errors++; $display("FAIL rst_mid got busy=%b arv=%b mid=%b data=%h required 0 0 0 0", busy, ar_valid, ar_mid, ar_data);
    end
    rst = 1'b0; req_valid = 2'b11; #1;
    checks++;
    if (req_ready !== 2'b01) begin
      errors++; $display("FAIL rst_ptr got rdy=%b required 01", req_ready);
    end
    req_valid = 2'b01; step(); req_valid = '0; ar_ready = 1'b1; step(); ar_ready = 1'b0;
    rst = 1'b1; step();
    rst = 1'b0; req_valid = 2'b10; #1;
    checks++;
    if (req_ready !== 2'b10) begin
      errors++; $display("FAIL rst_m1_grant got rdy=%b required 10", req_ready);
    end
    step(); req_valid = '0; #1;
    checks++;
    if (ar_valid !== 1'b1 || ar_mid !== 1'b1 || ar_data !== M1) begin
      errors++; $display("FAIL rst_m1_ar got v=%b mid=%b data=%h", ar_valid, ar_mid, ar_data);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    to_data(2'b01);
`ifdef AXI_ARB_TIMEOUT_EN
    for (int k = 1; k <= 8; k++) begin
      #1;
      checks++;
      if (timeout !== (k == 8) || busy !== 1'b1) begin
        errors++; $display("FAIL wd_cycle[%0d] got to=%b busy=%b", k, timeout, busy);
      end
      step();
    end
    checks++;
    if (busy !== 1'b0 || timeout !== 1'b0) begin
      errors++; $display("FAIL wd_after got busy=%b to=%b required 0 0", busy, timeout);
    end
`else
    for (int k = 0; k < 20; k++) begin
      #1;
      checks++;
      if (busy !== 1'b1 || timeout !== 1'b0) begin
        errors++; $display("FAIL no_wd[%0d] got busy=%b to=%b required 1 0", k, busy, timeout);
      end
      step();
    end
`endif
  endtask

  initial begin
    test_reset();
    test_first_grant();
    test_alternate();
    test_ar_stall();
    test_burst();
    test_reset_mid();
    test_timeout();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
